// File: rtl/uart_rx_if.sv
// Receive-side bundle of the UART receiver: serial line and frame options in,
// received word and error pulses out.
interface uart_rx_if #(
  parameter int DATA_WIDTH = 8
) ();
  logic                  i_rx_in;
  logic                  i_par_en;
  logic                  i_par_typ;
  logic [DATA_WIDTH-1:0] o_data;
  logic                  o_data_valid;
  logic                  o_par_err;
  logic                  o_stp_err;

  modport slave (
    input  i_rx_in,
    input  i_par_en,
    input  i_par_typ,
    output o_data,
    output o_data_valid,
    output o_par_err,
    output o_stp_err
  );

  modport master (
    output i_rx_in,
    output i_par_en,
    output i_par_typ,
    input  o_data,
    input  o_data_valid,
    input  o_par_err,
    input  o_stp_err
  );
endinterface

// File: rtl/uart_rx.sv
// UART receiver: 2-flop synchronized input, PRESCALE-times oversampling with a
// 3-sample majority vote per bit, optional even/odd parity, one stop bit.
module uart_rx #(
  parameter int DATA_WIDTH = 8,
  parameter int PRESCALE   = 8
) (
  input logic      i_clk,
  input logic      i_rst_n,
  uart_rx_if.slave bus
);
  localparam int EW = $clog2(PRESCALE);
  localparam int BW = $clog2(DATA_WIDTH);
  localparam logic [EW-1:0] EDGE_LAST = EW'(PRESCALE - 1);
  localparam logic [EW-1:0] SAMP_A    = EW'(PRESCALE / 2 - 1);
  localparam logic [EW-1:0] SAMP_B    = EW'(PRESCALE / 2);
  localparam logic [EW-1:0] SAMP_C    = EW'(PRESCALE / 2 + 1);
  localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_WIDTH - 1);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } state_t;

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

  function automatic logic calc_parity(input logic [DATA_WIDTH-1:0] d, input logic odd);
    return (^d) ^ odd;
  endfunction

  state_t                r_state, w_state_nxt;
  logic [EW-1:0]         r_edge_cnt, w_edge_nxt, w_edge_inc;
  logic [BW-1:0]         r_bit_cnt, w_bit_nxt;
  logic [DATA_WIDTH-1:0] r_shift, w_shift_nxt;
  logic                  r_par_bad, w_par_bad_nxt;
  logic                  r_par_en, r_par_typ;
  logic [1:0]            r_sync;
  logic [1:0]            r_samp;
  logic                  w_rx, w_bit, w_decide, w_last_edge, w_cfg_load, w_resolve;
  logic [DATA_WIDTH-1:0] r_data;
  logic                  r_data_valid, r_par_err, r_stp_err;

  assign w_rx        = r_sync[1];
  assign w_bit       = maj3(r_samp[0], r_samp[1], w_rx);
  assign w_decide    = (r_edge_cnt == SAMP_C);
  assign w_last_edge = (r_edge_cnt == EDGE_LAST);
  assign w_edge_inc  = r_edge_cnt + EW'(1);

  // Two-flop synchronizer; resets to the idle line level.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sync <= 2'b11;
    end else begin
      r_sync <= {r_sync[0], bus.i_rx_in};
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_samp <= 2'b11;
    end else if (r_edge_cnt == SAMP_A) begin
      r_samp[0] <= w_rx;
    end else if (r_edge_cnt == SAMP_B) begin
      r_samp[1] <= w_rx;
    end else begin
      r_samp <= r_samp;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state    <= ST_IDLE;
      r_edge_cnt <= '0;
      r_bit_cnt  <= '0;
      r_shift    <= '0;
      r_par_bad  <= 1'b0;
      r_par_en   <= 1'b0;
      r_par_typ  <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_edge_cnt <= w_edge_nxt;
      r_bit_cnt  <= w_bit_nxt;
      r_shift    <= w_shift_nxt;
      r_par_bad  <= w_par_bad_nxt;
      if (w_cfg_load) begin
        r_par_en  <= bus.i_par_en;
        r_par_typ <= bus.i_par_typ;
      end
    end
  end

  // Bit decisions happen at SAMP_C using the two stored samples plus the live one.
  always_comb begin
    w_state_nxt   = r_state;
    w_edge_nxt    = w_last_edge ? '0 : w_edge_inc;
    w_bit_nxt     = r_bit_cnt;
    w_shift_nxt   = r_shift;
    w_par_bad_nxt = r_par_bad;
    w_cfg_load    = 1'b0;
    w_resolve     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (!w_rx) begin
          w_state_nxt   = ST_START;
          w_edge_nxt    = EW'(1);
          w_bit_nxt     = '0;
          w_par_bad_nxt = 1'b0;
          w_cfg_load    = 1'b1;
        end else begin
          w_edge_nxt = '0;
        end
      end
      ST_START: begin
        if (w_decide && w_bit) begin
          w_state_nxt = ST_IDLE;
          w_edge_nxt  = '0;
        end else if (w_last_edge) begin
          w_state_nxt = ST_DATA;
        end else begin
          w_state_nxt = ST_START;
        end
      end
      ST_DATA: begin
        if (w_decide) begin
          w_shift_nxt = {w_bit, r_shift[DATA_WIDTH-1:1]};
        end else begin
          w_shift_nxt = r_shift;
        end
        if (w_last_edge) begin
          if (r_bit_cnt == BIT_LAST) begin
            w_bit_nxt   = '0;
            w_state_nxt = r_par_en ? ST_PARITY : ST_STOP;
          end else begin
            w_bit_nxt = r_bit_cnt + BW'(1);
          end
        end else begin
          w_bit_nxt = r_bit_cnt;
        end
      end
      ST_PARITY: begin
        if (w_decide) begin
          w_par_bad_nxt = (w_bit != calc_parity(r_shift, r_par_typ));
        end else begin
          w_par_bad_nxt = r_par_bad;
        end
        if (w_last_edge) begin
          w_state_nxt = ST_STOP;
        end else begin
          w_state_nxt = ST_PARITY;
        end
      end
      ST_STOP: begin
        // Leave at the stop decision so a start bit right after the stop bit is caught.
        if (w_decide) begin
          w_resolve   = 1'b1;
          w_state_nxt = ST_IDLE;
          w_edge_nxt  = '0;
        end else begin
          w_state_nxt = ST_STOP;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_edge_nxt  = '0;
        w_bit_nxt   = '0;
      end
    endcase
  end

  // Frame resolution: one-cycle pulses, data only updated on an error-free frame.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_data       <= '0;
      r_data_valid <= 1'b0;
      r_par_err    <= 1'b0;
      r_stp_err    <= 1'b0;
    end else begin
      r_data_valid <= 1'b0;
      r_par_err    <= 1'b0;
      r_stp_err    <= 1'b0;
      if (w_resolve) begin
        if (w_bit) begin
          if (r_par_bad) begin
            r_par_err <= 1'b1;
          end else begin
            r_data_valid <= 1'b1;
            r_data       <= r_shift;
          end
        end else begin
          r_stp_err <= 1'b1;
          r_par_err <= r_par_bad;
        end
      end
    end
  end

  assign bus.o_data       = r_data;
  assign bus.o_data_valid = r_data_valid;
  assign bus.o_par_err    = r_par_err;
  assign bus.o_stp_err    = r_stp_err;
endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx: frames are described by content, the expected outcome and
// its arrival cycle are computed from the frame rules and checked every cycle.
module tb_uart_rx;
  localparam int DW = 8;
  localparam int P  = 8;

  typedef struct {
    int            at_edge;
    logic          v;
    logic          pe;
    logic          se;
    logic [DW-1:0] d;
  } ev_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   cyc   = 0;
  int   n_checks = 0;
  int   n_fail   = 0;
  int   n_valid_seen = 0;
  int   n_perr_seen  = 0;
  int   n_serr_seen  = 0;
  int   last_valid_cyc = -1;
  logic [DW-1:0] model_data = '0;
  ev_t  exp_q[$];
  logic ev_v, ev_pe, ev_se;

  uart_rx_if #(.DATA_WIDTH(DW)) bus ();

  uart_rx #(.DATA_WIDTH(DW), .PRESCALE(P)) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference: outputs are zero except on the cycle a queued frame outcome is due.
  always @(negedge clk) begin
    ev_v  = 1'b0;
    ev_pe = 1'b0;
    ev_se = 1'b0;
    if (!rst_n) begin
      model_data = '0;
      exp_q.delete();
    end else if (exp_q.size() > 0 && exp_q[0].at_edge == cyc) begin
      ev_v  = exp_q[0].v;
      ev_pe = exp_q[0].pe;
      ev_se = exp_q[0].se;
      if (ev_v) model_data = exp_q[0].d;
      void'(exp_q.pop_front());
    end
    chk("data_valid", bus.o_data_valid, ev_v);
    chk("par_err", bus.o_par_err, ev_pe);
    chk("stp_err", bus.o_stp_err, ev_se);
    chk("data", bus.o_data, model_data);
    if (bus.o_data_valid) begin
      n_valid_seen++;
      last_valid_cyc = cyc;
    end
    if (bus.o_par_err) n_perr_seen++;
    if (bus.o_stp_err) n_serr_seen++;
  end

  task automatic idle(input int n);
    bus.i_rx_in = 1'b1;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic glitch(input int len);
    bus.i_rx_in = 1'b0;
    repeat (len) begin
      @(posedge clk);
      #1;
    end
    idle(2 * P);
  endtask

  // Drives one frame at exactly P cycles per bit. abort_bit >= 0 pulses reset inside that bit.
  task automatic send_frame(input logic [DW-1:0] d, input logic pe, input logic pt,
                            input logic flip_par, input logic stop_val, input logic corrupt,
                            input logic toggle_cfg, input int abort_bit, output int start_edge);
    logic bits[$];
    logic par_bad;
    ev_t  e;
    bits.push_back(1'b0);
    for (int i = 0; i < DW; i++) bits.push_back(d[i]);
    if (pe) bits.push_back((^d) ^ pt ^ flip_par);
    bits.push_back(stop_val);
    par_bad = pe & flip_par;
    bus.i_par_en  = pe;
    bus.i_par_typ = pt;
    start_edge = cyc + 1;
    if (abort_bit < 0) begin
      e.at_edge = start_edge + 2 + (1 + DW + int'(pe)) * P + P / 2 + 1;
      e.v  = stop_val & ~par_bad;
      e.pe = par_bad;
      e.se = ~stop_val;
      e.d  = d;
      exp_q.push_back(e);
    end
    for (int b = 0; b < bits.size(); b++) begin
      for (int k = 0; k < P; k++) begin
        if (b == abort_bit && k == 2) begin
          rst_n = 1'b0;
          bus.i_rx_in = 1'b1;
          repeat (3) begin
            @(posedge clk);
            #1;
          end
          rst_n = 1'b1;
          return;
        end
        bus.i_rx_in = (corrupt && k == P / 2 - 1) ? ~bits[b] : bits[b];
        if (toggle_cfg && b == 3 && k == 0) begin
          bus.i_par_en  = ~pe;
          bus.i_par_typ = ~pt;
        end
        @(posedge clk);
        #1;
      end
    end
    bus.i_rx_in = 1'b1;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL timeout: run did not complete (cycle %0d)", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    int st;
    int base;
    logic pe, pt, flip, stp, cor, tog;
    logic [DW-1:0] d;
    bus.i_rx_in   = 1'b1;
    bus.i_par_en  = 1'b0;
    bus.i_par_typ = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_data", bus.o_data, 32'h0);
    chk("reset_valid", bus.o_data_valid, 32'h0);
    rst_n = 1'b1;
    idle(4);

    // 8N1 0xA5: valid pulse 79 edges after the first low sample.
    last_valid_cyc = -1;
    send_frame(8'hA5, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, -1, st);
    idle(4);
    chk("lat_8N1", 32'(last_valid_cyc - st), 32'd79);
    chk("data_A5", bus.o_data, 32'hA5);

    // 8E1 0x3C good parity, then flipped parity.
    send_frame(8'h3C, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, -1, st);
    idle(4);
    chk("data_3C", bus.o_data, 32'h3C);
    base = n_perr_seen;
    send_frame(8'h3C, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, -1, st);
    idle(4);
    chk("par_err_cnt", 32'(n_perr_seen - base), 32'd1);
    chk("data_keep_3C", bus.o_data, 32'h3C);

    // 8O1 0x01 with parity bit 0, then with config toggled mid-frame.
    last_valid_cyc = -1;
    send_frame(8'h01, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, -1, st);
    idle(4);
    chk("lat_8O1", 32'(last_valid_cyc - st), 32'd87);
    chk("data_01", bus.o_data, 32'h01);
    send_frame(8'h01, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, -1, st);
    idle(4);
    chk("data_01_tog", bus.o_data, 32'h01);

    // Start glitch, then a clean frame.
    base = n_valid_seen;
    glitch(3);
    chk("glitch_no_valid", 32'(n_valid_seen - base), 32'd0);
    send_frame(8'h55, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, -1, st);
    idle(4);
    chk("data_55", bus.o_data, 32'h55);

    // Stop bit low, then back-to-back frames.
    base = n_serr_seen;
    send_frame(8'h7E, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, -1, st);
    idle(2 * P);
    chk("stp_err_cnt", 32'(n_serr_seen - base), 32'd1);
    chk("data_keep_55", bus.o_data, 32'h55);
    base = n_valid_seen;
    send_frame(8'h12, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, -1, st);
    chk("data_12", bus.o_data, 32'h12);
    send_frame(8'h34, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, -1, st);
    idle(4);
    chk("b2b_valid_cnt", 32'(n_valid_seen - base), 32'd2);
    chk("data_34", bus.o_data, 32'h34);

    // One bad sample per bit, then reset during bit 4, then a clean frame.
    send_frame(8'h96, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, -1, st);
    idle(4);
    chk("data_96_vote", bus.o_data, 32'h96);
    send_frame(8'hC3, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4, st);
    chk("rst_data", bus.o_data, 32'h0);
    idle(2 * P);
    chk("rst_data_hold", bus.o_data, 32'h0);
    send_frame(8'h5A, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, -1, st);
    idle(4);
    chk("data_5A", bus.o_data, 32'h5A);

    // Random frames; the compare process carries the checking.
    for (int i = 0; i < 40; i++) begin
      d    = DW'($urandom);
      pe   = 1'($urandom);
      pt   = 1'($urandom);
      flip = pe & ($urandom_range(0, 9) == 0);
      stp  = ($urandom_range(0, 9) != 0);
      cor  = ($urandom_range(0, 2) == 0);
      tog  = 1'($urandom);
      send_frame(d, pe, pt, flip, stp, cor, tog, -1, st);
      if (stp) idle($urandom_range(0, P));
      else     idle(2 * P + $urandom_range(0, P));
    end

    for (int w = 0; w < 200 && exp_q.size() > 0; w++) begin
      @(posedge clk);
      #1;
    end
    chk("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- UART receiver; the receive-side counterpart to the team's UART transmitter. It uses the same frame format: start bit (0), DATA_WIDTH data bits LSB-first, optional parity bit, one stop bit (1).
- Oversamples the serial line at PRESCALE clocks per bit and decides each bit by a 3-sample majority vote.
- Delivers each received word with a one-cycle valid pulse, and flags parity and framing errors.
- Sits between the pad-side serial input and the system-side consumer.

Parameters:
- DATA_WIDTH, 8: number of data bits per frame (5..9).
- PRESCALE, 8: i_clk cycles per bit. Must be even and ≥4.

Ports:
- i_clk  in  1  system clock.
- i_rst_n  in  1  asynchronous active-low reset.
- i_rx_in  in  1  serial line. Asynchronous to i_clk; idles high.
- i_par_en  in  1  1 = frame carries a parity bit.
- i_par_typ  in  1  0 = even parity, 1 = odd parity.
- o_data  out  DATA_WIDTH  last correctly received word.
- o_data_valid  out  1  one-cycle pulse: o_data updated, frame error-free.
- o_par_err  out  1  one-cycle pulse: parity mismatch.
- o_stp_err  out  1  one-cycle pulse: stop bit sampled 0.

Behaviour:
- Reset (async, i_rst_n=0):
  - State goes to IDLE; all counters are cleared.
  - Both synchronizer flops are set to 1.
  - o_data=0; o_data_valid, o_par_err and o_stp_err are 0.
  - Reset mid-frame abandons the frame with no flags.
- Input synchronization: i_rx_in passes through a 2-flop synchronizer (rx_s). All logic uses rx_s only.
- Counters:
  - edge_cnt runs 0..PRESCALE-1 within each bit.
  - bit_cnt runs 0..DATA_WIDTH-1 during DATA.
- Sampling:
  - rx_s is captured when edge_cnt = P/2-1, P/2 and P/2+1.
  - The bit value is the majority of the three samples and is resolved at edge_cnt = P/2+1 (the "decision point").
- States:
  - IDLE:
    - edge_cnt is held at 0.
    - When rx_s=0, latch i_par_en and i_par_typ for the whole frame, go to START and set edge_cnt=1. The detection cycle counts as edge 0.
  - START:
    - At the decision point, a bit value of 1 is a glitch: return to IDLE with no outputs.
    - Otherwise wait until edge_cnt=P-1, then go to DATA with edge_cnt=0.
  - DATA:
    - At each decision point, shift the bit into shift_reg LSB-first.
    - At edge_cnt=P-1, increment bit_cnt.
    - After bit DATA_WIDTH-1 completes, go to PARITY if the latched par_en=1, else to STOP.
  - PARITY:
    - Expected parity is the XOR of the data bits, inverted when par_typ=1.
    - At the decision point, store mismatch in par_bad.
    - At edge_cnt=P-1, go to STOP.
  - STOP: at the decision point, resolve the frame and go to IDLE immediately. The remaining half bit is not waited out, which allows back-to-back frames.
- Frame resolution (outputs registered, visible on the cycle after the stop decision point):
  - stop=1 and !par_bad: o_data<=shift_reg, o_data_valid=1.
  - stop=1 and par_bad: o_par_err=1; o_data is unchanged.
  - stop=0: o_stp_err=1, plus o_par_err=1 if par_bad; o_data is unchanged.
  - Flags and valid deassert the following cycle.
- Latency: o_data_valid is high after rising edge number 2 + (1+DATA_WIDTH+par_en)·P + P/2+1, counted from the first edge that samples i_rx_in=0. For 8N1 with P=8 this is edge 79.
- Line held low (break): produces o_stp_err. IDLE then re-detects low immediately and starts a new frame. This is accepted behaviour.
- i_par_en and i_par_typ changes mid-frame have no effect on the current frame.
- Unreachable state encodings recover to IDLE.

Test Plan:
- 8N1, P=8, send 0xA5 at exactly P cycles/bit -> o_data_valid pulse at edge 79 after the start edge; o_data=0xA5; no error flags.
- 8E1, send 0x3C with correct even parity (0) -> o_data=0x3C with valid. Repeat with the parity bit flipped -> o_par_err pulse, no valid, o_data keeps 0x3C.
- 8O1 with i_par_typ=1, send 0x01 with parity bit 0 -> valid, o_data=0x01. Toggle i_par_en mid-frame -> same result.
- 3-cycle low glitch on an idle line -> FSM returns to IDLE, no pulses. A following 0x55 frame is received correctly.
- Stop bit driven 0 on 0x7E -> o_stp_err pulse, no valid, o_data unchanged. Back-to-back frames 0x12 then 0x34 with the second start bit immediately after the stop bit -> two valid pulses in order.
- One sample per bit corrupted at P/2-1, and asserting i_rst_n=0 during bit 4 -> corrupted frame still decodes correctly by majority vote. Reset mid-frame clears all outputs to 0 and the next frame decodes cleanly.
